// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, DMA and DataMem signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        dma_err;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack, dma_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // CPU / DMA / DataMem side
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack, dma_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA DataMem arbiter; MEM_ARBITER_STARVE_EN enables the DMA forced grant
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
    end

    state_t      state_q, state_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        dma_err_q, dma_err_d;

    logic cpu_busy;
    logic dma_periph;
    logic starved;
    logic grant_go;

    assign cpu_busy   = bus.cpu_rd | bus.cpu_wr;
    assign dma_periph = bus.dma_addr[30];

`ifdef MEM_ARBITER_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starved = bus.dma_req && (starve_cnt_q == LIMIT);
`else
    assign starved = 1'b0;
`endif

    assign grant_go = (state_q == IDLE) && ((bus.dma_req && !cpu_busy) || starved);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dma_rdata_q <= 32'h0;
            dma_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dma_rdata_q <= dma_rdata_d;
            dma_err_q   <= dma_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_go) state_d = GRANT;
            GRANT:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARBITER_STARVE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Waiting cycles are only counted while the DMA sits behind CPU traffic.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (grant_go) begin
                starve_cnt_d = 4'd0;
            end else if (bus.dma_req && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end
`endif

    // The error flag is captured in GRANT and lives only through ACK.
    always_comb begin
        dma_rdata_d = dma_rdata_q;
        dma_err_d   = dma_err_q;
        case (state_q)
            GRANT: begin
                dma_err_d = dma_periph;
                if (!dma_periph && !bus.dma_we) begin
                    dma_rdata_d = bus.mem_rdata;
                end
            end
            ACK:     dma_err_d = 1'b0;
            default: dma_err_d = dma_err_q;
        endcase
    end

    always_comb begin
        bus.mem_rd    = bus.cpu_rd;
        bus.mem_wr    = bus.cpu_wr;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_stall = 1'b0;
        bus.dma_ack   = 1'b0;
        case (state_q)
            GRANT: begin
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                bus.mem_wr    = bus.dma_we & ~dma_periph;
                bus.mem_rd    = ~bus.dma_we & ~dma_periph;
`ifdef MEM_ARBITER_STARVE_EN
                bus.cpu_stall = cpu_busy;
`endif
            end
            ACK:     bus.dma_ack = 1'b1;
            default: bus.dma_ack = 1'b0;
        endcase
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.dma_err   = dma_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   bad;
    logic [8:0]  ack_vec;
    logic [31:0] mem [0:255];

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem model: combinational read, write on rising edge, preloaded while in reset
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            mem[0]  <= 32'h1111_1111;
            mem[4]  <= 32'hDEAD_BEEF;
            mem[12] <= 32'h0000_0000;
            mem[17] <= 32'hCAFE_F00D;
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0;
        bus.dma_we = 1'b0;
        bus.dma_addr = 32'h0;
        bus.dma_wdata = 32'h0;

        // Reset state: port follows the CPU, DMA outputs cleared
        #2;
        bus.cpu_rd = 1'b1;
        bus.cpu_addr = 32'h0000_0020;
        #1;
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_ack", bus.dma_ack, 0);
        chk("rst_err", bus.dma_err, 0);
        chk("rst_rdata", bus.dma_rdata, 32'h0);
        chk("rst_mem_rd", bus.mem_rd, 1);
        chk("rst_mem_addr", bus.mem_addr, 32'h0000_0020);
        tick();
        tick();
        bus.cpu_rd = 1'b0;
        reset = 1'b1;

        // CPU pass-through with simultaneous read and write
        bus.cpu_rd = 1'b1;
        bus.cpu_wr = 1'b1;
        bus.cpu_addr = 32'h0000_0044;
        bus.cpu_wdata = 32'h0000_1234;
        #1;
        chk("cpu_mem_rd", bus.mem_rd, 1);
        chk("cpu_mem_wr", bus.mem_wr, 1);
        chk("cpu_mem_addr", bus.mem_addr, 32'h0000_0044);
        chk("cpu_mem_wdata", bus.mem_wdata, 32'h0000_1234);
        chk("cpu_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
        chk("cpu_stall_idle", bus.cpu_stall, 0);
        tick();
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = 32'h0;
        chk("cpu_write_mem", mem[17], 32'h0000_1234);

        // DMA read with idle CPU: grant next cycle, ack two cycles after request
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b0;
        bus.dma_addr = 32'h0000_0010;
        #1;
        chk("rd_req_mem_rd", bus.mem_rd, 0);
        chk("rd_req_ack", bus.dma_ack, 0);
        tick();
        chk("rd_grant_mem_rd", bus.mem_rd, 1);
        chk("rd_grant_mem_wr", bus.mem_wr, 0);
        chk("rd_grant_addr", bus.mem_addr, 32'h0000_0010);
        chk("rd_grant_stall", bus.cpu_stall, 0);
        chk("rd_grant_ack", bus.dma_ack, 0);
        tick();
        chk("rd_ack", bus.dma_ack, 1);
        chk("rd_rdata", bus.dma_rdata, 32'hDEAD_BEEF);
        chk("rd_err", bus.dma_err, 0);
        chk("rd_ack_mem_rd", bus.mem_rd, 0);
        bus.dma_req = 1'b0;
        tick();
        chk("rd_after_ack", bus.dma_ack, 0);

        // DMA write into peripheral space is rejected
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b1;
        bus.dma_addr = 32'h4000_0000;
        bus.dma_wdata = 32'h55AA_55AA;
        tick();
        chk("per_mem_wr", bus.mem_wr, 0);
        chk("per_mem_rd", bus.mem_rd, 0);
        tick();
        chk("per_ack", bus.dma_ack, 1);
        chk("per_err", bus.dma_err, 1);
        chk("per_rdata_kept", bus.dma_rdata, 32'hDEAD_BEEF);
        bus.dma_req = 1'b0;
        tick();
        chk("per_err_clear", bus.dma_err, 0);
        chk("per_ack_clear", bus.dma_ack, 0);
        chk("per_mem_untouched", mem[0], 32'h1111_1111);

        // Back-to-back DMA reads: one ack every third cycle
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b0;
        bus.dma_addr = 32'h0000_0010;
        ack_vec = 9'h0;
        for (int i = 0; i < 9; i++) begin
            ack_vec[i] = bus.dma_ack;
            tick();
        end
        bus.dma_req = 1'b0;
        chk("b2b_ack_pattern", {23'h0, ack_vec}, 32'h0000_0124);
        tick();

`ifdef MEM_ARBITER_STARVE_EN
        // Starvation: forced grant after STARVE_LIMIT wait cycles, one stall cycle
        bus.cpu_rd = 1'b1;
        bus.cpu_addr = 32'h0000_0080;
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b1;
        bus.dma_addr = 32'h0000_0030;
        bus.dma_wdata = 32'hA5A5_0001;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.cpu_stall || !bus.mem_rd || bus.mem_wr || bus.dma_ack
                || bus.mem_addr != 32'h0000_0080) bad++;
            tick();
        end
        chk("stv_wait_cycles", bad, 0);
        chk("stv_grant_stall", bus.cpu_stall, 1);
        chk("stv_grant_mem_wr", bus.mem_wr, 1);
        chk("stv_grant_mem_rd", bus.mem_rd, 0);
        chk("stv_grant_addr", bus.mem_addr, 32'h0000_0030);
        tick();
        chk("stv_ack", bus.dma_ack, 1);
        chk("stv_ack_stall", bus.cpu_stall, 0);
        chk("stv_ack_mem_rd", bus.mem_rd, 1);
        bus.dma_req = 1'b0;
        tick();
        chk("stv_mem_written", mem[12], 32'hA5A5_0001);
        chk("stv_idle_stall", bus.cpu_stall, 0);
        bus.cpu_rd = 1'b0;
`else
        // Strict CPU priority: no grant while the CPU keeps writing
        bus.cpu_wr = 1'b1;
        bus.cpu_addr = 32'h0000_0080;
        bus.cpu_wdata = 32'h0000_0077;
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b1;
        bus.dma_addr = 32'h0000_0030;
        bus.dma_wdata = 32'hA5A5_0001;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.cpu_stall || bus.dma_ack || !bus.mem_wr || bus.mem_rd
                || bus.mem_addr != 32'h0000_0080) bad++;
            tick();
        end
        chk("prio_no_grant", bad, 0);
        bus.cpu_wr = 1'b0;
        #1;
        chk("prio_idle_mem_wr", bus.mem_wr, 0);
        tick();
        chk("prio_grant_mem_wr", bus.mem_wr, 1);
        chk("prio_grant_addr", bus.mem_addr, 32'h0000_0030);
        chk("prio_grant_stall", bus.cpu_stall, 0);
        tick();
        chk("prio_ack", bus.dma_ack, 1);
        bus.dma_req = 1'b0;
        tick();
        chk("prio_mem_written", mem[12], 32'hA5A5_0001);
        chk("prio_cpu_written", mem[32], 32'h0000_0077);
`endif

        // Reset during GRANT aborts the access
        bus.dma_req = 1'b1;
        bus.dma_we = 1'b0;
        bus.dma_addr = 32'h0000_0010;
        tick();
        chk("abort_grant_mem_rd", bus.mem_rd, 1);
        reset = 1'b0;
        #1;
        chk("abort_mem_rd", bus.mem_rd, 0);
        chk("abort_stall", bus.cpu_stall, 0);
        chk("abort_ack", bus.dma_ack, 0);
        chk("abort_rdata", bus.dma_rdata, 32'h0);
        tick();
        chk("abort_ack_held", bus.dma_ack, 0);
        bus.dma_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("abort_ack_release", bus.dma_ack, 0);

        // DMA reissues after reset
        bus.dma_req = 1'b1;
        tick();
        tick();
        chk("reissue_ack", bus.dma_ack, 1);
        chk("reissue_rdata", bus.dma_rdata, 32'hDEAD_BEEF);
        bus.dma_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4, number of cycles the DMA may wait behind CPU traffic before a forced grant; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock, no other clock domain.
REQ-004 cpu_rd  input  1  MEM-stage read request (MEM_MemRd).
REQ-005 cpu_wr  input  1  MEM-stage write request (MEM_MemWr).
REQ-006 cpu_addr  input  32  MEM-stage byte address (MEM_ALUOut).
REQ-007 cpu_wdata  input  32  MEM-stage store data.
REQ-008 cpu_rdata  output  32  read data to MEM stage; combinational copy of mem_rdata.
REQ-009 cpu_stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM, and bubble MEM/WB this cycle.
REQ-010 dma_req  input  1  DMA access request; held high until dma_ack.
REQ-011 dma_we  input  1  1 = write, 0 = read; stable while dma_req high.
REQ-012 dma_addr  input  32  DMA byte address; stable while dma_req high.
REQ-013 dma_wdata  input  32  DMA write data; stable while dma_req high.
REQ-014 dma_rdata  output  32  registered DMA read data; valid in dma_ack cycle.
REQ-015 dma_ack  output  1  one-cycle completion pulse.
REQ-016 dma_err  output  1  qualifies dma_ack: access rejected (peripheral space).
REQ-017 mem_rd, mem_wr  output  1 each  DataMem port strobes.
REQ-018 mem_addr, mem_wdata  output  32 each  DataMem address and write data.
REQ-019 mem_rdata  input  32  DataMem combinational read data.

Function
REQ-020 States IDLE, GRANT, ACK; state register only; port muxing combinational from state.
REQ-021 IDLE: memory port driven by cpu_* signals; cpu_stall=0; dma_ack=0.
REQ-022 IDLE->GRANT when dma_req=1 and (cpu_rd|cpu_wr)=0, or when starve_cnt==STARVE_LIMIT.
REQ-023 starve_cnt (4 bits) increments in IDLE each cycle dma_req=1 and no transition to GRANT; saturates at STARVE_LIMIT; clears on entering GRANT.
REQ-024 GRANT (exactly one cycle): mem_addr=dma_addr, mem_wdata=dma_wdata, mem_wr=dma_we, mem_rd=~dma_we; cpu_stall=cpu_rd|cpu_wr.
REQ-025 GRANT with dma_addr[30]=1: mem_rd=mem_wr=0, dma_err set, dma_rdata unchanged.
REQ-026 GRANT read with dma_addr[30]=0: dma_rdata loads mem_rdata at end of cycle.
REQ-027 GRANT->ACK unconditionally; ACK: dma_ack=1, dma_err per REQ-025, port back to CPU, cpu_stall=0.
REQ-028 ACK->IDLE unconditionally; dma_req sampled in ACK is ignored; DMA drops dma_req the cycle after dma_ack.
REQ-029 DMA latency: request to dma_ack minimum 2 cycles (idle CPU), maximum STARVE_LIMIT+2 cycles.
REQ-030 CPU never stalls more than one consecutive cycle per DMA access; simultaneous cpu_rd and cpu_wr passed through unchanged.

Reset
REQ-031 reset low: state=IDLE, starve_cnt=0, dma_rdata=0, dma_err=0; hence dma_ack=0, cpu_stall=0, mem port follows CPU.
REQ-032 reset asserted in GRANT aborts the access; no dma_ack issued; DMA reissues after reset.

Configuration
REQ-033 Macro MEM_ARBITER_STARVE_EN defined: forced grant per REQ-022/023 active.
REQ-034 Macro undefined: starve_cnt removed, strict CPU priority, DMA granted only on CPU-idle cycles, cpu_stall constantly 0.

Verification
REQ-035 CPU idle, dma_req read addr 0x00000010, memory word 0xDEADBEEF -> mem_rd high next cycle, dma_ack with dma_rdata=0xDEADBEEF 2 cycles after request.
REQ-036 cpu_rd held high continuously, dma_req write, STARVE_LIMIT=4 -> GRANT after 4 wait cycles, cpu_stall high exactly 1 cycle, memory written, dma_ack next cycle.
REQ-037 DMA write to 0x40000000 -> mem_wr stays 0, dma_ack=1 with dma_err=1, dma_rdata unchanged.
REQ-038 reset pulled low during GRANT -> state IDLE immediately, dma_ack never asserted, cpu_stall=0.
REQ-039 MEM_ARBITER_STARVE_EN undefined, cpu_wr high 20 cycles with dma_req pending -> no grant, cpu_stall=0; grant first cycle CPU idle.
REQ-040 Back-to-back DMA requests with CPU idle -> one access per 3 cycles, dma_ack pulses never adjacent.
